// File: rtl/fetch_unit_pkg.sv
// Shared CPU defines: datapath widths, fetch FSM encodings and the IF/ID register layout.
package fetch_unit_pkg;

   localparam int XLEN   = 64;
   localparam int ILEN   = 32;
   localparam int IFID_W = ILEN + XLEN + 1;

   localparam logic [1:0] ST_REQ   = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;
   localparam logic [1:0] ST_DRAIN = 2'd3;

   typedef struct packed {
      logic [ILEN-1:0] instr;
      logic [XLEN-1:0] pc;
      logic            vld;
   } ifid_t;

   // Fetch targets are word aligned; low bits of a redirect target are dropped.
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
      return {pc[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, a one-entry skid buffer for
// responses that land while IF/ID is stalled, and redirect/drain handling.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_0000_0000
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req_valid,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_resp_valid,
   input  logic [ILEN-1:0] imem_resp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            stall,
   output logic [ILEN-1:0] instruction_out,
   output logic [XLEN-1:0] pc_out,
   output logic            valid_out
);

   logic [1:0]      state;
   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] req_pc;
   ifid_t           hold;
   ifid_t           out_r;
   logic            out_open;
   logic            req_fire;

   assign out_open = !stall || !out_r.vld;
   assign req_fire = (state == ST_REQ) && imem_req_ready;

   assign imem_req_valid  = (state == ST_REQ) && !reset;
   assign imem_req_addr   = fetch_pc;
   assign instruction_out = out_r.instr;
   assign pc_out          = out_r.pc;
   assign valid_out       = out_r.vld;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_REQ;
         fetch_pc <= RESET_PC;
         req_pc   <= '0;
         hold     <= '0;
         out_r    <= '0;
      end else if (redirect_valid) begin
         // Redirect beats stall; an in-flight request must be drained first.
         fetch_pc  <= align_pc(redirect_pc);
         out_r.vld <= 1'b0;
         hold      <= '0;
         case (state)
            ST_REQ:  state <= req_fire ? ST_DRAIN : ST_REQ;
            ST_WAIT: state <= ST_DRAIN;
            ST_HOLD: state <= ST_REQ;
            default: state <= imem_resp_valid ? ST_REQ : ST_DRAIN;
         endcase
      end else begin
         if (out_open)
            out_r.vld <= 1'b0;
         case (state)
            ST_REQ: begin
               if (imem_req_ready) begin
                  req_pc   <= fetch_pc;
                  fetch_pc <= fetch_pc + 64'd4;
                  state    <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (imem_resp_valid) begin
                  if (out_open) begin
                     out_r <= '{instr: imem_resp_data, pc: req_pc, vld: 1'b1};
                     state <= ST_REQ;
                  end else begin
                     hold  <= '{instr: imem_resp_data, pc: req_pc, vld: 1'b1};
                     state <= ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (out_open && hold.vld) begin
                  out_r <= '{instr: hold.instr, pc: hold.pc, vld: 1'b1};
                  hold  <= '0;
                  state <= ST_REQ;
               end
            end
            default: begin
               // Discard the response belonging to the pre-redirect request.
               if (imem_resp_valid)
                  state <= ST_REQ;
            end
         endcase
      end
   end

endmodule
